// File: rtl/config_stream_loader_pkg.sv
// rtl/config_stream_loader_pkg.sv - shared types and constants for the configuration stream loader
// Purpose: parser/driver state encodings, address field widths, default end marker,
//          and the (addr, data) pair record carried through the pair FIFO.
// Ports:   none (package).
package config_stream_loader_pkg;

  localparam int TILE_ID_W   = 16;
  localparam int CONFIG_ID_W = 16;

  localparam logic [31:0] DEFAULT_DONE_ADDR = 32'hFFFF_FFFF;

  typedef enum logic {
    P_ADDR,
    P_DATA
  } parser_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WRITE,
    D_SETTLE
  } driver_state_t;

  // addr = {tile_id, config register id}
  typedef struct packed {
    logic [TILE_ID_W+CONFIG_ID_W-1:0] addr;
    logic [31:0]                      data;
  } pair_t;

endpackage

// File: rtl/config_pair_fifo.sv
// rtl/config_pair_fifo.sv - 64-bit (addr, data) pair FIFO with registered full/empty flags
// Purpose: buffers complete configuration pairs between the stream parser and the bus driver.
// Ports:   clk, reset (async active-low), push/wdata (ignored when full),
//          pop (ignored when empty), rdata (head entry), full, empty.
module config_pair_fifo
  import config_stream_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  pair_t wdata,
  input  logic  pop,
  output pair_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the flags
  // disambiguate the rd_ptr == wr_ptr case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          empty  <= 1'b0;
          full   <= ((wr_ptr + PTR_ONE) == rd_ptr);
        end
        2'b01: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          full   <= 1'b0;
          empty  <= ((rd_ptr + PTR_ONE) == wr_ptr);
        end
        2'b11: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - host word stream to tile configuration bus writer
// Purpose: parses alternating address/data words into pairs, buffers them, and
//          broadcasts each as a one-cycle config_write followed by a settle window.
//          An address equal to DONE_ADDR ends configuration (sticky config_done).
// Ports:   clk, reset (async active-low), in_valid/in_data/in_ready (host words),
//          config_addr/config_data/config_write (tile bus), busy, config_done,
//          write_count (only when CONFIG_STREAM_LOADER_COUNT_EN is defined).
// Option:  `define CONFIG_STREAM_LOADER_COUNT_EN adds the saturating write_count output.
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 4,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] DONE_ADDR     = DEFAULT_DONE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
  output logic        config_done,
  output logic [15:0] write_count
`else
  output logic        config_done
`endif
);

  localparam int CNT_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  parser_state_t p_state;
  driver_state_t d_state;
  logic [31:0]   addr_q;
  logic          done_pending;
  logic [CNT_W-1:0] settle_cnt;

  logic  in_xfer;
  logic  ready_raw;
  logic  fifo_push;
  logic  fifo_pop;
  logic  fifo_full;
  logic  fifo_empty;
  pair_t push_pair;
  pair_t head_pair;

  // in_ready depends only on registered state (and the reset pin), never on in_valid.
  // The full flag is the registered one, so a pop in the same cycle does not open a slot.
  assign ready_raw = (p_state == P_ADDR) ? !done_pending : !fifo_full;
  assign in_ready  = reset && ready_raw;
  assign in_xfer   = in_valid && in_ready;

  assign fifo_push      = in_xfer && (p_state == P_DATA) && (addr_q != DONE_ADDR);
  assign push_pair.addr = addr_q;
  assign push_pair.data = in_data;

  assign fifo_pop = (d_state == D_IDLE) && !fifo_empty;

  config_pair_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata(push_pair),
    .pop  (fifo_pop),
    .rdata(head_pair),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state      <= P_ADDR;
      addr_q       <= '0;
      done_pending <= 1'b0;
    end else if (in_xfer) begin
      case (p_state)
        P_ADDR: begin
          addr_q  <= in_data;
          p_state <= P_DATA;
        end
        P_DATA: begin
          // The data word following the end marker is consumed and dropped.
          if (addr_q == DONE_ADDR) begin
            done_pending <= 1'b1;
          end
          p_state <= P_ADDR;
        end
        default: p_state <= P_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_state      <= D_IDLE;
      settle_cnt   <= '0;
      config_addr  <= '0;
      config_data  <= '0;
      config_write <= 1'b0;
    end else begin
      case (d_state)
        D_IDLE: begin
          config_write <= 1'b0;
          if (!fifo_empty) begin
            config_addr  <= head_pair.addr;
            config_data  <= head_pair.data;
            config_write <= 1'b1;
            d_state      <= D_WRITE;
          end
        end
        D_WRITE: begin
          config_write <= 1'b0;
          if (SETTLE_CYCLES == 0) begin
            d_state <= D_IDLE;
          end else begin
            settle_cnt <= CNT_W'(SETTLE_LOAD);
            d_state    <= D_SETTLE;
          end
        end
        D_SETTLE: begin
          config_write <= 1'b0;
          if (settle_cnt == '0) begin
            d_state <= D_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
          config_write <= 1'b0;
          d_state      <= D_IDLE;
        end
      endcase
    end
  end

  assign busy = (p_state == P_DATA) || !fifo_empty || (d_state != D_IDLE);

  // Once done_pending is set nothing more is pushed, so this term is
  // self-holding until reset.
  assign config_done = done_pending && fifo_empty && (d_state == D_IDLE);

`ifdef CONFIG_STREAM_LOADER_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_count <= '0;
    end else if (config_write && (write_count != 16'hFFFF)) begin
      write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - self-checking bench for config_stream_loader
module tb_config_stream_loader;

  logic        clk;
  logic        reset;
  logic        in_valid, in_valid0;
  logic [31:0] in_data, in_data0;
  logic        in_ready, in_ready0;
  logic [31:0] config_addr, config_addr0;
  logic [31:0] config_data, config_data0;
  logic        config_write, config_write0;
  logic        busy, busy0;
  logic        config_done, config_done0;
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
  logic [15:0] write_count, write_count0;
`endif

  config_stream_loader #(.FIFO_DEPTH(4), .SETTLE_CYCLES(2), .DONE_ADDR(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .config_addr(config_addr), .config_data(config_data), .config_write(config_write),
    .busy(busy),
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
    .write_count(write_count),
`endif
    .config_done(config_done)
  );

  config_stream_loader #(.FIFO_DEPTH(4), .SETTLE_CYCLES(0), .DONE_ADDR(32'hFFFF_FFFF)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
    .config_addr(config_addr0), .config_data(config_data0), .config_write(config_write0),
    .busy(busy0),
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
    .write_count(write_count0),
`endif
    .config_done(config_done0)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_spacing;
  } vec_t;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  stall_data = 0;
  int  stall_addr = 0;
  int  exp_count  = 0;
  int  lp [2];
  wr_t wq[$], wq0[$], eq[$], eq0[$];
  vec_t vecs [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (config_write)  wq.push_back('{cyc, config_addr, config_data});
    if (config_write0) wq0.push_back('{cyc, config_addr0, config_data0});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [31:0] w, input bit is_data, output int xc);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    xc = -1;
    if (sel) begin in_valid0 = 1'b1; in_data0 = w; end
    else     begin in_valid  = 1'b1; in_data  = w; end
    while (!ok && n < 40) begin
      @(negedge clk);
      if (sel ? in_ready0 : in_ready) begin
        xc = cyc;
        ok = 1'b1;
      end else if (is_data) stall_data++;
      else stall_addr++;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) check("xfer_timeout", {63'd0, ok}, 64'd1);
  endtask

  // Predicts the write cycle of each pair: 2 cycles after its data word, but
  // no sooner than one full write+settle period after the previous write.
  task automatic send_pair(input bit sel, input logic [31:0] a, input logic [31:0] d);
    int xa, xd, s, p;
    s = sel ? 0 : 2;
    send(sel, a, 1'b0, xa);
    send(sel, d, 1'b1, xd);
    p = xd + 2;
    if (lp[sel] + 2 + s > p) p = lp[sel] + 2 + s;
    lp[sel] = p;
    if (sel) eq0.push_back('{p, a, d});
    else begin
      eq.push_back('{p, a, d});
      exp_count++;
    end
  endtask

  task automatic cmp_queue(input bit sel, input string name);
    wr_t got[$], want[$];
    int  m;
    if (sel) begin got = wq0; want = eq0; end
    else     begin got = wq;  want = eq;  end
    check({name, "_nwrites"}, 64'(got.size()), 64'(want.size()));
    m = (got.size() < want.size()) ? got.size() : want.size();
    for (int i = 0; i < m; i++) begin
      check({name, "_cycle"}, 64'(got[i].cyc), 64'(want[i].cyc));
      check({name, "_addr"},  {32'd0, got[i].addr}, {32'd0, want[i].addr});
      check({name, "_data"},  {32'd0, got[i].data}, {32'd0, want[i].data});
    end
    if (sel) begin wq0.delete(); eq0.delete(); end
    else     begin wq.delete();  eq.delete();  end
  endtask

  initial begin
    int xd, rise, seen, errs;
    bit found;

    vecs[0] = '{32'h0002_0010, 32'h1111_0000, 0};
    vecs[1] = '{32'h0002_0011, 32'h2222_0001, 4};
    vecs[2] = '{32'h0003_0000, 32'h3333_0002, 4};
    vecs[3] = '{32'h0003_0001, 32'h4444_0003, 4};
    vecs[4] = '{32'h0004_00FF, 32'h5555_0004, 4};
    vecs[5] = '{32'h0005_1234, 32'h6666_0005, 4};
    vecs[6] = '{32'h0006_0000, 32'h7777_0006, 4};
    vecs[7] = '{32'h0007_0007, 32'h8888_0007, 4};
    vecs[8] = '{32'h0008_ABCD, 32'h9999_0008, 4};
    vecs[9] = '{32'h0009_0009, 32'hAAAA_0009, 4};

    lp[0] = -100; lp[1] = -100;
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0;
    in_valid0 = 1'b0; in_data0 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_addr", {32'd0, config_addr}, 64'd0);
    check("rst_data", {32'd0, config_data}, 64'd0);
    check("rst_write", {63'd0, config_write}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, config_done}, 64'd0);
    check("rst_in_ready0", {63'd0, in_ready0}, 64'd0);
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
    check("rst_count", {48'd0, write_count}, 64'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Single pair: strobe 2 cycles after the data word, held through settle
    send_pair(1'b0, 32'h0001_0001, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("single_write_t%0d", k), {63'd0, config_write}, {63'd0, (k == 2)});
      check($sformatf("single_busy_t%0d", k), {63'd0, busy}, {63'd0, (k < 5)});
      if (k >= 2) begin
        check($sformatf("single_addr_t%0d", k), {32'd0, config_addr}, 64'h0001_0001);
        check($sformatf("single_data_t%0d", k), {32'd0, config_data}, 64'hDEAD_BEEF);
      end
    end
    repeat (4) @(posedge clk); #1;
    cmp_queue(1'b0, "single");

    // Back-to-back stream with in_valid held: data words stall on a full FIFO
    stall_data = 0; stall_addr = 0;
    for (int i = 0; i < 10; i++) send_pair(1'b0, vecs[i].addr, vecs[i].data);
    in_valid = 1'b0;
    repeat (50) @(posedge clk); #1;
    check("b2b_stall_on_data", {63'd0, (stall_data > 0)}, 64'd1);
    check("b2b_stall_on_addr", 64'(stall_addr), 64'd0);
    check("b2b_nwrites_tbl", 64'(wq.size()), 64'd10);
    if (wq.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("b2b_addr_%0d", i), {32'd0, wq[i].addr}, {32'd0, vecs[i].addr});
        check($sformatf("b2b_data_%0d", i), {32'd0, wq[i].data}, {32'd0, vecs[i].data});
        if (i > 0)
          check($sformatf("b2b_spacing_%0d", i), 64'(wq[i].cyc - wq[i-1].cyc), 64'(vecs[i].exp_spacing));
      end
    end
    cmp_queue(1'b0, "b2b");

    // Done marker after two pairs
    send_pair(1'b0, 32'h0010_0001, 32'h0BAD_F00D);
    send_pair(1'b0, 32'h0010_0002, 32'hCAFE_0002);
    send(1'b0, 32'hFFFF_FFFF, 1'b0, xd);
    send(1'b0, 32'h1234_5678, 1'b1, xd);
    in_valid = 1'b0;
    rise = lp[0] + 3;
    if (xd + 1 > rise) rise = xd + 1;
    found = 1'b0; seen = -1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (config_done) begin found = 1'b1; seen = cyc; end
    end
    check("done_rise_cycle", 64'(seen), 64'(rise));
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h0020_0000;
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || config_done !== 1'b1) errs++;
    end
    in_valid = 1'b0;
    check("done_sticky_no_ready", 64'(errs), 64'd0);
    cmp_queue(1'b0, "done");
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
    check("count_after_done", {48'd0, write_count}, 64'(exp_count));
`endif

    // Reset mid-stream
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst2_done", {63'd0, config_done}, 64'd0);
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
    check("rst2_count", {48'd0, write_count}, 64'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    lp[0] = -100; wq.delete(); eq.delete(); exp_count = 0;
    for (int i = 0; i < 6; i++) send_pair(1'b0, vecs[i].addr ^ 32'h00F0_0000, vecs[i].data);
    in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (config_write) found = 1'b1;
    end
    check("mid_saw_write", {63'd0, found}, 64'd1);
    reset = 1'b0;
    #1;
    check("mid_write_async", {63'd0, config_write}, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_in_ready", {63'd0, in_ready}, 64'd0);
    check("mid_addr_cleared", {32'd0, config_addr}, 64'd0);
    @(negedge clk); reset = 1'b1;
    wq.delete(); eq.delete();
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || config_done !== 1'b0 || in_ready !== 1'b1) errs++;
    end
    check("post_reset_idle", 64'(errs), 64'd0);
    check("post_reset_no_writes", 64'(wq.size()), 64'd0);
    @(posedge clk); #1;

    // Zero settle window: strobes on alternating cycles
    for (int i = 0; i < 4; i++) send_pair(1'b1, vecs[i].addr, vecs[i].data ^ 32'hFFFF_0000);
    in_valid0 = 1'b0;
    repeat (8) @(posedge clk); #1;
    if (wq0.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check($sformatf("s0_spacing_%0d", i), 64'(wq0[i].cyc - wq0[i-1].cyc), 64'd2);
    end
    cmp_queue(1'b1, "settle0");
`ifdef CONFIG_STREAM_LOADER_COUNT_EN
    check("count0", {48'd0, write_count0}, 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
